// File: rtl/aib_cfg_avmm_responder_if.sv
// aib_cfg_avmm_responder_if: Avalon-MM config port between the calibration initiator and the config responder.
interface aib_cfg_avmm_responder_if #(
    parameter int AVMM_WIDTH = 32,
    parameter int BYTE_WIDTH = 4,
    parameter int ADDR_WIDTH = 17
);
    logic [ADDR_WIDTH-1:0] addr;
    logic [BYTE_WIDTH-1:0] byte_en;
    logic                  read;
    logic                  write;
    logic [AVMM_WIDTH-1:0] wdata;
    logic                  rdatavld;
    logic [AVMM_WIDTH-1:0] rdata;
    logic                  waitreq;
    modport master (output addr, byte_en, read, write, wdata, input rdatavld, rdata, waitreq);
    modport slave  (input addr, byte_en, read, write, wdata, output rdatavld, rdata, waitreq);
endinterface

// File: rtl/aib_cfg_avmm_responder.sv
// aib_cfg_avmm_responder: AVMM config target with a word register file, programmable stall and fixed-latency reads.
module aib_cfg_avmm_responder #(
    parameter int AVMM_WIDTH   = 32,
    parameter int BYTE_WIDTH   = 4,
    parameter int ADDR_WIDTH   = 17,
    parameter int NUM_REGS     = 16,
    parameter int WAIT_CYCLES  = 1,
    parameter int RD_LATENCY   = 2,
    parameter int STATUS_WIDTH = 32
) (
    input  logic                                 i_cfg_avmm_clk,
    input  logic                                 i_cfg_avmm_rst,
    aib_cfg_avmm_responder_if.slave              avmm,
    input  logic [STATUS_WIDTH-1:0]              i_status,
    output logic [(NUM_REGS-1)*AVMM_WIDTH-1:0]   o_cfg_regs,
    output logic                                 o_err
);
    localparam int IDX_W = $clog2(NUM_REGS);
    typedef enum logic [1:0] {IDLE, STALL, ACK} state_t;
    state_t                                r_state;
    logic [3:0]                            r_cnt;
    logic                                  r_waitreq;
    logic                                  r_err;
    logic [NUM_REGS-2:0][AVMM_WIDTH-1:0]   r_regs;
    logic [RD_LATENCY-1:0]                 r_vld;
    logic [RD_LATENCY-1:0][AVMM_WIDTH-1:0] r_dat;
    logic [NUM_REGS-1:0][AVMM_WIDTH-1:0]   w_file;
    logic [IDX_W-1:0]                      w_idx;
    logic [AVMM_WIDTH-1:0]                 w_rdata;
    logic w_req, w_oor, w_ro, w_acc, w_wr, w_rd, w_err_set;
    assign w_req  = avmm.read | avmm.write;
    assign w_idx  = avmm.addr[IDX_W+1:2];
    assign w_oor  = avmm.addr >= ADDR_WIDTH'(NUM_REGS * 4);
    assign w_ro   = w_idx == IDX_W'(NUM_REGS - 1);
    assign w_acc  = r_state == ACK;
    assign w_wr   = w_acc & avmm.write;
    // a simultaneous read+write executes only the write
    assign w_rd   = w_acc & avmm.read & ~avmm.write;
    // the top word of the map is the live status, so reads see it at the accept edge
    assign w_file  = {AVMM_WIDTH'(i_status), r_regs};
    assign w_rdata = w_oor ? '0 : w_file[w_idx];
    assign w_err_set = ((r_state == STALL) & ~w_req)
                     | (w_acc & (~w_req | w_oor | (avmm.read & avmm.write)));
    always_ff @(posedge i_cfg_avmm_clk) begin
        if (i_cfg_avmm_rst) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_waitreq <= 1'b1;
            r_err     <= 1'b0;
            r_regs    <= '0;
            r_vld     <= '0;
            r_dat     <= '0;
        end else begin
            unique case (r_state)
                IDLE: if (w_req) begin
                    r_state   <= (WAIT_CYCLES == 0) ? ACK : STALL;
                    r_cnt     <= 4'(WAIT_CYCLES - 1);
                    r_waitreq <= WAIT_CYCLES != 0;
                end
                STALL: if (!w_req) begin
                    r_state <= IDLE;
                end else if (r_cnt == '0) begin
                    r_state   <= ACK;
                    r_waitreq <= 1'b0;
                end else begin
                    r_cnt <= r_cnt - 4'd1;
                end
                ACK: begin
                    r_state   <= IDLE;
                    r_waitreq <= 1'b1;
                end
                default: r_state <= IDLE;
            endcase
            r_err <= r_err | w_err_set;
            if (w_wr && !w_oor && !w_ro)
                for (int b = 0; b < BYTE_WIDTH; b++)
                    if (avmm.byte_en[b]) r_regs[w_idx][8*b +: 8] <= avmm.wdata[8*b +: 8];
            // data stages only move with a valid so rdata holds between pulses
            r_vld[0] <= w_rd;
            if (w_rd) r_dat[0] <= w_rdata;
            for (int i = 1; i < RD_LATENCY; i++) begin
                r_vld[i] <= r_vld[i-1];
                if (r_vld[i-1]) r_dat[i] <= r_dat[i-1];
            end
        end
    end
    assign avmm.waitreq  = r_waitreq;
    assign avmm.rdatavld = r_vld[RD_LATENCY-1];
    assign avmm.rdata    = r_dat[RD_LATENCY-1];
    assign o_cfg_regs    = r_regs;
    assign o_err         = r_err;
endmodule

// File: doc/aib_cfg_avmm_responder.md
Name: aib_cfg_avmm_responder

Overview:
Avalon-MM configuration responder (target) for the AIB bridge config port; the counterpart to the calibration FSM initiator that drives i_cfg_avmm_* addr/read/write/wdata/byte_en and consumes rdata/rdatavld/waitreq. Holds a small word-addressed register file, stalls each command with a programmable waitrequest, and returns read data through a fixed-latency pipeline. Used as the config target in follower-side integration and as a behavioural stand-in when verifying calibration sequencing.

Parameters:
AVMM_WIDTH, 32, data width in bits
BYTE_WIDTH, 4, byte-enable width (AVMM_WIDTH/8)
ADDR_WIDTH, 17, byte address width
NUM_REGS, 16, number of 32-bit registers (power of 2, >=2)
WAIT_CYCLES, 1, extra stall cycles before accept (0..15)
RD_LATENCY, 2, cycles from accept edge to o_cfg_avmm_rdatavld (1..8)
STATUS_WIDTH, 32, width of read-only status input

Ports:
i_cfg_avmm_clk  input  1  sole clock
i_cfg_avmm_rst  input  1  synchronous reset, active-high
i_cfg_avmm_addr  input  ADDR_WIDTH  byte address
i_cfg_avmm_byte_en  input  BYTE_WIDTH  write byte lanes
i_cfg_avmm_read  input  1  read request
i_cfg_avmm_write  input  1  write request
i_cfg_avmm_wdata  input  AVMM_WIDTH  write data
o_cfg_avmm_rdatavld  output  1  read data valid pulse
o_cfg_avmm_rdata  output  AVMM_WIDTH  read data
o_cfg_avmm_waitreq  output  1  stall; command accepted only when low
i_status  input  STATUS_WIDTH  read-only status (e.g. fs_mac_rdy/align_done)
o_cfg_regs  output  (NUM_REGS-1)*AVMM_WIDTH  flattened RW registers 0..NUM_REGS-2
o_err  output  1  sticky protocol/decode error

Behaviour:
- Clock/reset: one clock; reset synchronous, active-high. Reset: waitreq=1, rdatavld=0, rdata=0, all RW regs=0, o_err=0, FSM=IDLE, read pipeline flushed, stall counter=0.
- Decode: word index = addr[log2(NUM_REGS)+1:2]; addr[1:0] ignored. Addr >= NUM_REGS*4 is out-of-range.
- Map: index 0..NUM_REGS-2 RW; index NUM_REGS-1 RO = i_status zero-extended (sampled at accept edge); writes to it ignored, no error.
- FSM IDLE: waitreq=1. If read|write: WAIT_CYCLES==0 -> ACK, else STALL with cnt=WAIT_CYCLES-1.
- STALL: waitreq=1; cnt decrements; at cnt==0 -> ACK. If read and write both drop (initiator violation) -> IDLE, nothing performed, o_err set.
- ACK: waitreq=0 exactly one cycle; command executes on this edge; -> IDLE. Back-to-back commands cost WAIT_CYCLES+2 cycles each.
- Write: each byte lane i updated only if byte_en[i]; byte_en=0 accepted, no change. Out-of-range write: discarded, o_err set.
- Read: data captured at accept edge into RD_LATENCY-deep shift pipeline (valid+data); rdatavld pulses 1 cycle exactly RD_LATENCY cycles after ACK edge; rdata holds last value when rdatavld=0. Out-of-range read returns 0 with rdatavld, o_err set. Pipeline sustains overlapping reads (accepts never faster than pipeline drains).
- Read and write both high at accept: write performed, read dropped (no rdatavld), o_err set.
- Read-after-write same address, back-to-back: read returns new value.
- o_err sticky until reset.
- Reset mid-stall or with reads in flight: pending rdatavld suppressed; FSM to IDLE next cycle.

Test Plan:
- Reset, then write addr 0x0004 wdata 0xA5A5_1234 byte_en 0xF -> waitreq low exactly 1 cycle, 2 cycles after request (WAIT_CYCLES=1); o_cfg_regs[63:32]=0xA5A51234.
- Write addr 0x4 wdata 0xFFFF_FFFF byte_en 0x5 over 0xA5A51234 -> reg1=0xA5FF12FF; then read 0x4 -> rdatavld exactly 2 cycles after accept edge, rdata=0xA5FF12FF.
- i_status=0x0000_00C3, read addr 0x3C (NUM_REGS=16) -> rdata=0x000000C3; write 0x3C then read -> still 0xC3, o_err=0.
- Read addr 0x100 -> rdatavld with rdata=0, o_err=1; write 0x100 -> no reg change.
- read=write=1 at addr 0x8 wdata 0x55 -> reg2=0x55, no rdatavld, o_err=1.
- Issue read, assert i_cfg_avmm_rst 1 cycle after accept -> no rdatavld, waitreq=1, all regs 0.
